// File: rtl/boot_rom_copier_if.sv
// ============================================================================
// boot_rom_copier_if : boot-ROM read port plus REQ/GNT RAM write port
// Rev 1.0
// ============================================================================
`default_nettype none

interface boot_rom_copier_if #(
    parameter int ROM_AW = 10
);
    logic              rom_csn;
    logic [ROM_AW-1:0] rom_a;
    logic [31:0]       rom_q;
    logic              mem_req;
    logic              mem_gnt;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [3:0]        mem_be;

    modport master (
        output rom_csn, rom_a, mem_req, mem_addr, mem_wdata, mem_we, mem_be,
        input  rom_q, mem_gnt
    );

    modport slave (
        input  rom_csn, rom_a, mem_req, mem_addr, mem_wdata, mem_we, mem_be,
        output rom_q, mem_gnt
    );
endinterface

`default_nettype wire

// File: rtl/boot_rom_copier.sv
// ============================================================================
// boot_rom_copier : copies WORD_COUNT boot-ROM words into instruction RAM,
//                   then raises a sticky fetch enable for the core.
// Optional macro  : BOOT_ROM_COPIER_CHECKSUM_EN enables the CHECKSUM adder.
// Rev 1.0
// ============================================================================
`default_nettype none

module boot_rom_copier #(
    parameter int          ROM_AW     = 10,
    parameter int          WORD_COUNT = 839,
    parameter logic [31:0] DST_BASE   = 32'h0000_0000
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    input  wire logic         start_i,
    boot_rom_copier_if.master bus_io,
    output logic              busy_o,
    output logic              done_o,
    output logic              fetch_en_o,
    output logic [31:0]       checksum_o
);
    localparam int               IDX_W    = ROM_AW + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              rom_csn_q;
    logic [ROM_AW-1:0] rom_a_q;
    logic              mem_req_q;
    logic [31:0]       mem_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              xfer;
    logic [31:0]       word_addr;

    assign xfer      = mem_req_q & bus_io.mem_gnt;
    assign word_addr = DST_BASE + (32'(idx_q) << 2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rom_csn_q  <= 1'b1;
            rom_a_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= DST_BASE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q   <= S_RD;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        rom_csn_q <= 1'b0;
                        rom_a_q   <= '0;
                    end
                end
                S_RD: begin
                    state_q    <= S_WR;
                    rom_csn_q  <= 1'b1;
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= word_addr;
                end
                S_WR: begin
                    // Address and data hold while the grant is withheld.
                    if (xfer) begin
                        mem_req_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_RD;
                            idx_q     <= idx_q + 1'b1;
                            rom_csn_q <= 1'b0;
                            rom_a_q   <= ROM_AW'(idx_q + 1'b1);
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_FIN;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BOOT_ROM_COPIER_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            checksum_q <= '0;
        end else if (state_q == S_IDLE && start_i) begin
            checksum_q <= '0;
        end else if (xfer) begin
            checksum_q <= checksum_q + bus_io.rom_q;
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = 32'h0;
`endif

    // ROM output is held while CSN is high, so write data can pass straight through.
    assign bus_io.rom_csn   = rom_csn_q;
    assign bus_io.rom_a     = rom_a_q;
    assign bus_io.mem_req   = mem_req_q;
    assign bus_io.mem_addr  = mem_addr_q;
    assign bus_io.mem_wdata = bus_io.rom_q;
    assign bus_io.mem_we    = 1'b1;
    assign bus_io.mem_be    = 4'hF;

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign fetch_en_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_rom_copier.sv
// ============================================================================
// tb_boot_rom_copier : two copier instances (small image, full-ROM boundary)
//                      checked against ROM/RAM models and an image-based reference.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_boot_rom_copier;
    localparam int          AW    = 10;
    localparam int          WC_A  = 4;
    localparam logic [31:0] DST_A = 32'h0000_0100;
    localparam int          WC_B  = 1024;
    localparam logic [31:0] DST_B = 32'hFFFF_F000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        rst_a = 1'b1, start_a = 1'b0, busy_a, done_a, fen_a;
    logic        rst_b = 1'b1, start_b = 1'b0, busy_b, done_b, fen_b;
    logic [31:0] cks_a, cks_b;

    boot_rom_copier_if #(.ROM_AW(AW)) bus_a ();
    boot_rom_copier_if #(.ROM_AW(AW)) bus_b ();

    boot_rom_copier #(.ROM_AW(AW), .WORD_COUNT(WC_A), .DST_BASE(DST_A)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .bus_io(bus_a),
        .busy_o(busy_a), .done_o(done_a), .fetch_en_o(fen_a), .checksum_o(cks_a)
    );

    boot_rom_copier #(.ROM_AW(AW), .WORD_COUNT(WC_B), .DST_BASE(DST_B)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .bus_io(bus_b),
        .busy_o(busy_b), .done_o(done_b), .fetch_en_o(fen_b), .checksum_o(cks_b)
    );

    // ROM images and registered-read ROM models
    logic [31:0] img_a [1024];
    logic [31:0] img_b [1024];
    initial begin
        bus_a.rom_q = 32'h0;
        bus_b.rom_q = 32'h0;
    end
    always @(posedge clk) if (!bus_a.rom_csn) bus_a.rom_q <= img_a[bus_a.rom_a];
    always @(posedge clk) if (!bus_b.rom_csn) bus_b.rom_q <= img_b[bus_b.rom_a];

    // Grant driver for A: optional fixed stall on one address, optional random grant
    int          run_a = 0, run_b = 0;
    int          stall_run_a = 0, stall_used_a = 0, stall_len_a = 0;
    logic [31:0] stall_addr_a = 32'h0;
    bit          rand_gnt_a = 1'b0;
    always @(posedge clk) begin
        #1;
        if (run_a != stall_run_a) begin
            stall_run_a  = run_a;
            stall_used_a = 0;
        end
        if (bus_a.mem_req && bus_a.mem_addr == stall_addr_a && stall_used_a < stall_len_a) begin
            bus_a.mem_gnt = 1'b0;
            stall_used_a++;
        end else if (rand_gnt_a) begin
            bus_a.mem_gnt = ($urandom_range(0, 3) != 0);
        end else begin
            bus_a.mem_gnt = 1'b1;
        end
    end
    assign bus_b.mem_gnt = 1'b1;

    // Bus monitors (sampled on the falling edge)
    logic [31:0] waddr_a[$], wdata_a[$], waddr_b[$], wdata_b[$];
    int          rdq_a[$], rdq_b[$];
    int          seen_a = 0, seen_b = 0;
    int          csn_viol_a = 0, stab_err_a = 0, stalls_a = 0, csn_viol_b = 0;
    logic        pcsn_a = 1'b0, pstall_a = 1'b0, pcsn_b = 1'b0;
    logic [31:0] paddr_a = 32'h0, pdata_a = 32'h0;

    always @(negedge clk) begin
        if (run_a != seen_a) begin
            seen_a = run_a;
            waddr_a.delete(); wdata_a.delete(); rdq_a.delete();
            csn_viol_a = 0; stab_err_a = 0; stalls_a = 0;
        end
        if (rst_a) begin
            pcsn_a   = 1'b0;
            pstall_a = 1'b0;
        end else begin
            if (!bus_a.rom_csn) begin
                if (pcsn_a) csn_viol_a++;
                rdq_a.push_back(int'(bus_a.rom_a));
            end
            pcsn_a = !bus_a.rom_csn;
            if (bus_a.mem_req && bus_a.mem_gnt) begin
                waddr_a.push_back(bus_a.mem_addr);
                wdata_a.push_back(bus_a.mem_wdata);
            end
            if (pstall_a && bus_a.mem_req &&
                (bus_a.mem_addr != paddr_a || bus_a.mem_wdata != pdata_a)) stab_err_a++;
            if (bus_a.mem_req && !bus_a.mem_gnt) stalls_a++;
            pstall_a = bus_a.mem_req && !bus_a.mem_gnt;
            paddr_a  = bus_a.mem_addr;
            pdata_a  = bus_a.mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (run_b != seen_b) begin
            seen_b = run_b;
            waddr_b.delete(); wdata_b.delete(); rdq_b.delete();
            csn_viol_b = 0;
        end
        if (rst_b) begin
            pcsn_b = 1'b0;
        end else begin
            if (!bus_b.rom_csn) begin
                if (pcsn_b) csn_viol_b++;
                rdq_b.push_back(int'(bus_b.rom_a));
            end
            pcsn_b = !bus_b.rom_csn;
            if (bus_b.mem_req && bus_b.mem_gnt) begin
                waddr_b.push_back(bus_b.mem_addr);
                wdata_b.push_back(bus_b.mem_wdata);
            end
        end
    end

    task automatic reset_a();
        rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
    endtask

    // Pulse START, then count edges from the sampling edge until DONE is seen.
    task automatic kick_a(input int budget, output int cycles);
        run_a++;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        cycles = 0;
        while (!done_a && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic kick_b(input int budget, output int cycles);
        run_b++;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        cycles = 0;
        while (!done_b && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    function automatic logic [31:0] ref_sum_a();
        logic [31:0] s = 32'h0;
`ifdef BOOT_ROM_COPIER_CHECKSUM_EN
        for (int i = 0; i < WC_A; i++) s += img_a[i];
`endif
        return s;
    endfunction

    task automatic test_reset();
        rst_a = 1'b1;
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus_a.rom_csn, bus_a.rom_a, bus_a.mem_req} !== {1'b1, 10'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_bus: got csn=%b a=%0d req=%b want csn=1 a=0 req=0",
                     bus_a.rom_csn, bus_a.rom_a, bus_a.mem_req);
        end
        n_cmp++;
        if ({busy_a, done_a, fen_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status: got busy/done/fen=%b want 000", {busy_a, done_a, fen_a});
        end
        n_cmp++;
        if (bus_a.mem_addr !== DST_A || cks_a !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr_cks: got addr=%h cks=%h want addr=%h cks=0",
                     bus_a.mem_addr, cks_a, DST_A);
        end
        n_cmp++;
        if ({bus_a.mem_we, bus_a.mem_be} !== 5'b11111) begin
            n_fail++;
            $display("FAIL reset_we_be: got we=%b be=%h want we=1 be=f", bus_a.mem_we, bus_a.mem_be);
        end
        #1 rst_a = 1'b0;
    endtask

    task automatic test_basic_copy();
        int cyc;
        img_a[0] = 32'h11; img_a[1] = 32'h22; img_a[2] = 32'h33; img_a[3] = 32'h44;
        rand_gnt_a  = 1'b0;
        stall_len_a = 0;
        reset_a();
        kick_a(50, cyc);
        n_cmp++;
        if (cyc !== 2 * WC_A) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles want %0d", cyc, 2 * WC_A);
        end
        n_cmp++;
        if ({done_a, fen_a, busy_a} !== 3'b110) begin
            n_fail++;
            $display("FAIL basic_done: got done/fen/busy=%b want 110", {done_a, fen_a, busy_a});
        end
        n_cmp++;
        if (waddr_a.size() !== WC_A) begin
            n_fail++;
            $display("FAIL basic_wcount: got %0d writes want %0d", waddr_a.size(), WC_A);
        end
        for (int i = 0; i < WC_A && i < waddr_a.size(); i++) begin
            n_cmp++;
            if (waddr_a[i] !== DST_A + 32'(4 * i) || wdata_a[i] !== img_a[i]) begin
                n_fail++;
                $display("FAIL basic_write%0d: got %h<=%h want %h<=%h",
                         i, waddr_a[i], wdata_a[i], DST_A + 32'(4 * i), img_a[i]);
            end
        end
        n_cmp++;
`ifdef BOOT_ROM_COPIER_CHECKSUM_EN
        if (cks_a !== 32'hAA) begin
            n_fail++;
            $display("FAIL basic_checksum: got %h want %h", cks_a, 32'hAA);
        end
`else
        if (cks_a !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_checksum: got %h want 0", cks_a);
        end
`endif
    endtask

    task automatic test_backpressure();
        int cyc;
        stall_addr_a = DST_A + 32'h8;
        stall_len_a  = 3;
        reset_a();
        kick_a(50, cyc);
        n_cmp++;
        if (cyc !== 2 * WC_A + 3) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d cycles want %0d", cyc, 2 * WC_A + 3);
        end
        n_cmp++;
        if (stab_err_a !== 0 || stalls_a !== 3) begin
            n_fail++;
            $display("FAIL bp_stable: got unstable=%0d stalls=%0d want 0 and 3", stab_err_a, stalls_a);
        end
        n_cmp++;
        if (waddr_a.size() < 3 || waddr_a[2] !== 32'h108 || wdata_a[2] !== 32'h33) begin
            n_fail++;
            $display("FAIL bp_word2: got %0d writes want word2 = 108<=33", waddr_a.size());
        end
        stall_len_a = 0;
    endtask

    task automatic test_start_filter();
        int guard;
        reset_a();
        run_a++;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        guard = 0;
        while (!bus_a.mem_req && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        guard = 0;
        while (!done_a && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL filter_done: got done=%b want 1", done_a);
        end
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (rdq_a.size() !== WC_A || waddr_a.size() !== WC_A) begin
            n_fail++;
            $display("FAIL filter_counts: got reads=%0d writes=%0d want %0d each",
                     rdq_a.size(), waddr_a.size(), WC_A);
        end
        n_cmp++;
        if ({done_a, fen_a, busy_a, bus_a.rom_csn, bus_a.mem_req} !== 5'b11010) begin
            n_fail++;
            $display("FAIL filter_fin_hold: got done/fen/busy/csn/req=%b want 11010",
                     {done_a, fen_a, busy_a, bus_a.rom_csn, bus_a.mem_req});
        end
    endtask

    task automatic test_reset_mid_copy();
        int guard, cyc;
        reset_a();
        run_a++;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        guard = 0;
        while (!(bus_a.mem_req && bus_a.mem_addr == DST_A + 32'h4) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (guard >= 20) begin
            n_fail++;
            $display("FAIL midrst_reach_wr1: got timeout after %0d cycles want WR of word 1", guard);
        end
        rst_a = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus_a.mem_req, busy_a, done_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_state: got req/busy/done=%b want 000", {bus_a.mem_req, busy_a, done_a});
        end
        rst_a = 1'b0;
        kick_a(50, cyc);
        n_cmp++;
        if (cyc !== 2 * WC_A || waddr_a.size() !== WC_A || waddr_a[0] !== DST_A) begin
            n_fail++;
            $display("FAIL midrst_recopy: got cycles=%0d writes=%0d want %0d cycles, %0d writes from %h",
                     cyc, waddr_a.size(), 2 * WC_A, WC_A, DST_A);
        end
    endtask

    task automatic test_random();
        int cyc, bad;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < WC_A; i++) img_a[i] = $urandom;
            rand_gnt_a = 1'b1;
            reset_a();
            kick_a(200, cyc);
            n_cmp++;
            if (cyc !== 2 * WC_A + stalls_a) begin
                n_fail++;
                $display("FAIL rand%0d_latency: got %0d cycles want %0d", it, cyc, 2 * WC_A + stalls_a);
            end
            bad = (waddr_a.size() == WC_A && rdq_a.size() == WC_A) ? 0 : 1;
            for (int i = 0; i < WC_A && bad == 0; i++) begin
                if (waddr_a[i] !== DST_A + 32'(4 * i) || wdata_a[i] !== img_a[i] || rdq_a[i] != i) bad++;
            end
            n_cmp++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL rand%0d_writes: got writes=%0d reads=%0d with mismatching entries want %0d in order",
                         it, waddr_a.size(), rdq_a.size(), WC_A);
            end
            n_cmp++;
            if (csn_viol_a !== 0 || stab_err_a !== 0 || cks_a !== ref_sum_a()) begin
                n_fail++;
                $display("FAIL rand%0d_proto: got csn_viol=%0d unstable=%0d cks=%h want 0 0 %h",
                         it, csn_viol_a, stab_err_a, cks_a, ref_sum_a());
            end
        end
        rand_gnt_a = 1'b0;
    endtask

    task automatic test_boundary();
        int cyc, bad;
        logic [31:0] sum = 32'h0;
        for (int i = 0; i < WC_B; i++) begin
            img_b[i] = $urandom;
`ifdef BOOT_ROM_COPIER_CHECKSUM_EN
            sum += img_b[i];
`endif
        end
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
        kick_b(3000, cyc);
        n_cmp++;
        if (cyc !== 2 * WC_B || done_b !== 1'b1 || fen_b !== 1'b1) begin
            n_fail++;
            $display("FAIL bound_latency: got %0d cycles done=%b want %0d cycles done=1", cyc, done_b, 2 * WC_B);
        end
        n_cmp++;
        if (waddr_b.size() !== WC_B || waddr_b[WC_B-1] !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL bound_last_addr: got %0d writes want %0d ending at fffffffc", waddr_b.size(), WC_B);
        end
        bad = (rdq_b.size() == WC_B && wdata_b.size() == WC_B) ? 0 : 1;
        for (int i = 0; i < WC_B && bad == 0; i++) begin
            if (rdq_b[i] != i || wdata_b[i] !== img_b[i] || waddr_b[i] !== DST_B + 32'(4 * i)) bad++;
        end
        n_cmp++;
        if (bad !== 0 || csn_viol_b !== 0) begin
            n_fail++;
            $display("FAIL bound_rom_order: got reads=%0d csn_viol=%0d with mismatches want 0..1023 once each",
                     rdq_b.size(), csn_viol_b);
        end
        n_cmp++;
        if (cks_b !== sum) begin
            n_fail++;
            $display("FAIL bound_checksum: got %h want %h", cks_b, sum);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            img_a[i] = $urandom;
            img_b[i] = 32'h0;
        end
        test_reset();
        test_basic_copy();
        test_backpressure();
        test_start_filter();
        test_reset_mid_copy();
        test_random();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000 ns want completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/boot_rom_copier.md
# boot_rom_copier

Boot-time copy engine that reads a program image out of the boot ROM and writes it, word by word, into instruction RAM. The ROM side uses the boot ROM's read protocol (CSN/A in, Q out, registered address). The RAM side uses a REQ/GNT write port. The block sits between the boot ROM and the instruction-memory interconnect. When the copy finishes it raises a sticky fetch-enable to release the core.

## Interface
- ROM_AW, 10, boot ROM word-address width
- WORD_COUNT, 839, number of 32-bit words copied (1..2^ROM_AW)
- DST_BASE, 32'h0000_0000, byte address in RAM for ROM word 0 (word-aligned)

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  one-cycle pulse that begins the copy
- ROM_CSN  out  1  ROM chip select, active-low
- ROM_A  out  ROM_AW  ROM word address
- ROM_Q  in  32  ROM read data; valid the cycle after the cycle with ROM_CSN=0; held while ROM_CSN=1
- MEM_REQ  out  1  RAM write request
- MEM_GNT  in  1  RAM grant
- MEM_ADDR  out  32  RAM byte address
- MEM_WDATA  out  32  RAM write data
- MEM_WE  out  1  write enable; constant 1
- MEM_BE  out  4  byte enables; constant 4'hF
- BUSY  out  1  copy in progress
- DONE  out  1  copy complete (sticky)
- FETCH_EN  out  1  core fetch enable (sticky, equals DONE)
- CHECKSUM  out  32  running word sum (see Configuration)

## Operation
- The FSM has four states: IDLE, RD, WR, FIN. A word index register IDX is ROM_AW+1 bits wide.
- Reset drives the block to IDLE with:
  - IDX=0, ROM_CSN=1, ROM_A=0, MEM_REQ=0
  - BUSY=0, DONE=0, FETCH_EN=0, CHECKSUM=0
  - MEM_ADDR=DST_BASE
- **IDLE:** START=1 → RD, with IDX=0 and BUSY=1. START=0 stays in IDLE.
- **RD:** ROM_CSN=0, ROM_A=IDX[ROM_AW-1:0]. Next state is always WR.
- **WR:**
  - ROM_CSN=1. MEM_REQ=1, MEM_ADDR=DST_BASE+4*IDX, MEM_WDATA=ROM_Q.
  - MEM_WDATA is passed through combinationally; ROM_Q is stable because CSN is high.
  - The transfer completes in the cycle where MEM_REQ=1 and MEM_GNT=1.
  - On completion with IDX==WORD_COUNT-1: go to FIN.
  - On completion otherwise: IDX+1, go to RD.
  - MEM_GNT=0: stay in WR; ADDR and WDATA hold stable.
- **FIN:** BUSY=0, DONE=1, FETCH_EN=1, MEM_REQ=0, ROM_CSN=1. The block stays in FIN until RST.
- START is ignored outside IDLE (in RD, WR and FIN).
- MEM_GNT is ignored when MEM_REQ=0.
- MEM_ADDR arithmetic is modulo 2^32.
- ROM_A comes from the low ROM_AW bits of IDX. IDX never exceeds WORD_COUNT-1 while the block is issuing.
- RST mid-copy returns the block to IDLE on the next edge. Any in-flight request is dropped; the RAM keeps its partial contents. A new START restarts the copy from word 0.

## Timing
- START is sampled at edge E0. RD occupies cycle 1 and WR occupies cycle 2.
- With MEM_GNT tied to 1, each word takes 2 cycles.
- DONE and FETCH_EN rise at edge E0+2*WORD_COUNT.
- Each cycle of MEM_GNT=0 during WR adds 1 cycle.
- ROM_CSN is low for exactly one cycle per word and never in two consecutive cycles.
- MEM_REQ is deasserted for exactly one cycle (the RD cycle) between consecutive words.
- All outputs are registered except MEM_WDATA, MEM_WE and MEM_BE.

## Configuration
- Macro: `BOOT_ROM_COPIER_CHECKSUM_EN`.
- **Defined:**
  - CHECKSUM accumulates the 32-bit sum (mod 2^32) of every MEM_WDATA word on each completed transfer.
  - CHECKSUM is cleared on RST and on START accepted in IDLE, and holds its value in FIN.
- **Undefined:** CHECKSUM is tied to 32'h0 and no adder is synthesized.

## Test plan
1. **Basic copy:** WORD_COUNT=4, DST_BASE=32'h100, ROM words 0..3 = 32'h11,32'h22,32'h33,32'h44, MEM_GNT=1.
   - Writes go to 0x100, 0x104, 0x108, 0x10C with the matching data.
   - DONE=FETCH_EN=1 at 8 cycles after START.
   - CHECKSUM=32'hAA with the macro, 0 without.
2. **Backpressure:** same setup, MEM_GNT held low for 3 cycles on word 2.
   - MEM_ADDR=0x108 and MEM_WDATA=32'h33 stay stable through the stall.
   - DONE is asserted at 11 cycles after START.
3. **Reset values and START filtering:**
   - After RST: all outputs are at their reset values.
   - START pulsed in WR and again in FIN: no extra ROM_CSN pulses, no extra writes.
4. **Reset mid-copy:** RST asserted during WR of word 1.
   - Next cycle: MEM_REQ=0, BUSY=0, DONE=0.
   - A following START re-copies from address 0x100 and completes normally.
5. **Boundary:** WORD_COUNT=1024, ROM_AW=10, DST_BASE=32'hFFFF_F000.
   - The last write is to 0xFFFF_FFFC with ROM_A=1023.
   - No ROM access happens beyond 1023; DONE is set after 2048 cycles.
6. **ROM protocol:**
   - ROM_CSN is never low in consecutive cycles.
   - Each ROM_A value is issued exactly once, in ascending order.
